// File: rtl/ram8.sv
// ram8: eight-word register file with a 1-to-8 load decode and a sequenced
// clear sweep (one word per cycle, busy flag while sweeping).
// Optional build macro: RAM8_BYPASS_EN (write-through of `in` to `out` on an
// accepted load cycle).

// One storage word: loads d on the rising edge when we is high.
module ram8_word #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    // Word register, cleared asynchronously, otherwise written on we.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)  q <= '0;
        else if (we) q <= d;
    end

endmodule

module ram8 #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic [2:0]       address,
    input  logic             load,
    input  logic             clr,
    output logic [WIDTH-1:0] out,
    output logic             busy
);

    localparam int WORDS = 8;

    typedef enum logic {IDLE, CLEAR} state_t;

    // One write request shared by all words: per-word enables plus the data.
    typedef struct packed {
        logic [WORDS-1:0] en;
        logic [WIDTH-1:0] data;
    } wr_req_t;

    state_t                      state;
    logic [2:0]                  ptr;
    logic [WORDS-1:0]            addr_onehot;
    logic [WORDS-1:0]            load_line;
    logic [WORDS-1:0]            clear_line;
    wr_req_t                     wr_req;
    logic [WORDS-1:0][WIDTH-1:0] mem;
    logic [WIDTH-1:0]            rd_data;

    // Load demux: a user write is only accepted in IDLE and loses to clr.
    always_comb begin
        addr_onehot = '0;
        addr_onehot[address] = 1'b1;
        load_line = '0;
        if (load && (state == IDLE) && !clr)
            load_line = addr_onehot;
    end

    // Sweep decode: exactly the word under the pointer is zeroed while in CLEAR.
    always_comb begin
        clear_line = '0;
        if (state == CLEAR)
            clear_line[ptr] = 1'b1;
    end

    // Merge user writes and sweep writes; they are mutually exclusive by state.
    always_comb begin
        wr_req.en   = load_line | clear_line;
        wr_req.data = (state == CLEAR) ? '0 : in;
    end

    genvar gi;
    generate
        for (gi = 0; gi < WORDS; gi++) begin : g_word
            ram8_word #(.WIDTH(WIDTH)) u_word (
                .clk   (clk),
                .rst_n (rst_n),
                .we    (wr_req.en[gi]),
                .d     (wr_req.data),
                .q     (mem[gi])
            );
        end
    endgenerate

    // Clear-sweep FSM; busy is registered alongside the state so it mirrors CLEAR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            ptr   <= '0;
            busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (clr) begin
                        state <= CLEAR;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                CLEAR: begin
                    // The edge that zeroes word 7 ends the sweep; ptr wraps to 0.
                    ptr <= ptr + 3'd1;
                    if (ptr == 3'd7) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    ptr   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // Combinational read, no latency.
    always_comb begin
        rd_data = mem[address];
    end

`ifdef RAM8_BYPASS_EN
    // Write-through: an accepted load shows its data in the same cycle.
    // load_line is already zero during CLEAR, so the sweep never bypasses.
    always_comb begin
        out = load_line[address] ? in : rd_data;
    end
`else
    // Plain read: a write becomes visible only after the clock edge.
    always_comb begin
        out = rd_data;
    end
`endif

endmodule

// File: tb/tb_ram8.sv
// Self-checking bench for ram8: table-driven write/hold vectors plus
// hand-written sequences for reset, clear sweep and reset mid-sweep.
module tb_ram8;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic [WIDTH-1:0] in;
    logic [2:0]       address;
    logic             load;
    logic             clr;
    logic [WIDTH-1:0] out;
    logic             busy;

    int n_checks;
    int n_fail;

    ram8 #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .in      (in),
        .address (address),
        .load    (load),
        .clr     (clr),
        .out     (out),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             ld;
        logic [2:0]       addr;
        logic [WIDTH-1:0] din;
        logic [WIDTH-1:0] exp_old;   // value held before the edge
        logic [WIDTH-1:0] exp_after; // value after the edge
    } vec_t;

    vec_t vecs [16];

    task automatic check(input string name, input logic [WIDTH-1:0] got,
                         input logic [WIDTH-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, got, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [2:0] a, input logic [WIDTH-1:0] d);
        load = 1'b1; address = a; in = d;
        tick();
        load = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] exp_same;
        int cyc;

        n_checks = 0;
        n_fail   = 0;
        rst_n = 1'b0; in = '0; address = '0; load = 1'b0; clr = 1'b0;

        // ---------------- reset after filling with 0xFFFF ----------------
        #12 rst_n = 1'b1;
        tick();
        check("post_reset_busy", {15'd0, busy}, 16'd0);
        for (int i = 0; i < 8; i++) write_word(3'(i), 16'hFFFF);
        address = 3'd3; #1;
        check("fill_ffff", out, 16'hFFFF);
        #1 rst_n = 1'b0;     // mid-cycle
        #1;
        for (int i = 0; i < 8; i++) begin
            address = 3'(i); #1;
            check($sformatf("reset_clear_w%0d", i), out, 16'h0000);
        end
        check("reset_busy", {15'd0, busy}, 16'd0);
        @(posedge clk);      // registers hold while reset is low
        #1;
        address = 3'd0; #1;
        check("reset_hold", out, 16'h0000);
        rst_n = 1'b1;
        tick();

        // ---------------- table: write all words, then hold ----------------
        for (int i = 0; i < 8; i++) begin
            vecs[i]   = '{1'b1, 3'(i), 16'h1000 + 16'(i), 16'h0000, 16'h1000 + 16'(i)};
            vecs[8+i] = '{1'b0, 3'(i), 16'hBEEF, 16'h1000 + 16'(i), 16'h1000 + 16'(i)};
        end
        for (int v = 0; v < 16; v++) begin
            load = vecs[v].ld; address = vecs[v].addr; in = vecs[v].din;
            #1;
`ifdef RAM8_BYPASS_EN
            exp_same = vecs[v].ld ? vecs[v].din : vecs[v].exp_old;
`else
            exp_same = vecs[v].exp_old;
`endif
            check($sformatf("vec%0d_same_cycle", v), out, exp_same);
            tick();
            load = 1'b0; #1;
            check($sformatf("vec%0d_after", v), out, vecs[v].exp_after);
        end

        // ---------------- clear sweep with reads ----------------
        clr = 1'b1; load = 1'b1; address = 3'd2; in = 16'hAAAA;
        tick();              // sweep cycle 0 begins
        clr = 1'b0; load = 1'b0;
        #1;
        check("clr_drops_load", out, 16'h1002);
        address = 3'd5;
        for (int k = 0; k < 8; k++) begin
            #1;
            check($sformatf("sweep_busy_c%0d", k), {15'd0, busy}, 16'd1);
            check($sformatf("sweep_rd5_c%0d", k), out, (k <= 5) ? 16'h1005 : 16'h0000);
            tick();
        end
        check("sweep_busy_end", {15'd0, busy}, 16'd0);
        for (int i = 0; i < 8; i++) begin
            address = 3'(i); #1;
            check($sformatf("sweep_zero_w%0d", i), out, 16'h0000);
        end

        // ---------------- inputs ignored during CLEAR ----------------
        for (int i = 0; i < 8; i++) write_word(3'(i), 16'h1000 + 16'(i));
        clr = 1'b1;
        tick();
        clr = 1'b0;
        cyc = 0;
        while (busy && cyc < 20) begin
            load = 1'b0; clr = 1'b0; address = 3'd7;
            if (cyc == 0) begin load = 1'b1; address = 3'd7; in = 16'h5555; end
            if (cyc == 1) begin
                #1 check("ign_load_w7", out, 16'h1007);
            end
            if (cyc == 3) begin clr = 1'b1; load = 1'b1; address = 3'd0; in = 16'h5555; end
            if (cyc == 4) begin
                address = 3'd0;
                #1 check("ign_load_w0", out, 16'h0000);
            end
            tick();
            cyc++;
        end
        clr = 1'b0; load = 1'b0;
        check("ign_busy_len", 16'(cyc), 16'd8);
        address = 3'd7; #1;
        check("ign_w7_end", out, 16'h0000);
        tick();
        check("ign_no_restart", {15'd0, busy}, 16'd0);

        // ---------------- reset mid-sweep ----------------
        write_word(3'd6, 16'h0066);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        for (int k = 0; k < 4; k++) tick();   // now in sweep cycle 4
        address = 3'd6; #1;
        check("midsweep_w6_before", out, 16'h0066);
        rst_n = 1'b0; #1;
        check("midsweep_busy", {15'd0, busy}, 16'd0);
        check("midsweep_w6_zero", out, 16'h0000);
        #1 rst_n = 1'b1;
        tick();
        write_word(3'd1, 16'h0042);
        address = 3'd1; #1;
        check("post_abort_write", out, 16'h0042);
        check("post_abort_busy", {15'd0, busy}, 16'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/ram8.md
Name: ram8

Overview:
- Eight-word register file that consumes a 1-to-8 load demultiplex. The internal `load` decode is the DMux8Way stage. Each decoded line enables one WIDTH-bit register.
- This is the memory stage fed directly by the project-1 demux logic. It is the building block for larger RAM and for the CPU data path.
- Adds a sequenced clear, one word per cycle, with a busy flag.

Parameters:
- WIDTH, 16, data word width in bits (Hack word).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; asserting it immediately clears all state.
- in  input  WIDTH  write data.
- address  input  3  word select for both read and write.
- load  input  1  write enable; routed by the 1-to-8 demux to register[address].
- clr  input  1  single-cycle request to start the clear sweep.
- out  output  WIDTH  read data = register[address].
- busy  output  1  high while the clear sweep runs.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - all 8 registers = 0, busy=0, FSM=IDLE, sweep pointer=0.
  - out = 0 for every address.
  - Registers hold while rst_n is low; operation resumes on the first rising edge after release.
- Load decode:
  - load_line[i] = load & (address==i) & (state==IDLE) & ~clr.
  - Exactly one line is high, or none.
- Write:
  - On the rising edge, register[i] <= in when load_line[i]=1. Other registers hold.
- Read:
  - out is combinational from register[address]; there is no read latency.
  - In a load cycle, out shows the OLD value; the new value is visible from the cycle after the edge.
- FSM states: IDLE, CLEAR.
  - IDLE: clr=1 at an edge -> CLEAR, pointer <= 0.
    - clr has priority over load; a load in the same cycle is dropped.
  - CLEAR: each edge writes register[pointer] <= 0 and pointer <= pointer+1.
    - The edge that clears word 7 returns the FSM to IDLE and pointer wraps to 0.
- busy:
  - busy = (state==CLEAR), registered.
  - Goes high the cycle after clr is sampled and stays high exactly 8 cycles.
- During CLEAR:
  - load is ignored (no write).
  - clr is ignored; the sweep does not restart.
  - Reads are allowed and return current contents: already-cleared words read 0, words not yet cleared keep their data.
- Reset mid-sweep: the sweep aborts, state=IDLE, busy=0, all words are 0.
- Width: no arithmetic; in and out are both exactly WIDTH bits; there is no truncation.

Optional Feature:
- Macro: RAM8_BYPASS_EN.
- Defined:
  - When load_line[address] is high in a cycle (IDLE, no clr), out = in combinationally (write-through).
  - Otherwise out = register[address].
  - During CLEAR, out is never bypassed.
- Undefined: out = register[address] always; a write is visible only after the clock edge.

Test Plan:
- Reset: drive rst_n=0 mid-cycle after filling all words with 0xFFFF -> out=0x0000 immediately for address 0..7; busy=0.
- Write/read all words:
  - stimulus: load=1, address=i, in=0x1000+i for i=0..7.
  - required: out = 0x1000+i on readback of every address, no aliasing.
  - same-cycle out = old value (or = in when RAM8_BYPASS_EN is defined).
- Hold: load=0, in=0xBEEF, sweep address 0..7 -> contents unchanged (0x1000+i).
- Clear sweep with reads:
  - stimulus: pulse clr one cycle with load=1, address=2, in=0xAAAA.
  - required: no write; busy=1 for exactly 8 cycles.
  - Reading address 5 during cycles 1-5 of busy returns 0x1005; from cycle 6 it returns 0x0000.
  - After busy falls, all words = 0.
- Ignored inputs during CLEAR: load=1, address=7, in=0x5555 and a second clr pulse at sweep cycle 3 -> word 7 = 0 at end; busy still lasts 8 cycles total.
- Reset mid-sweep: rst_n=0 at sweep cycle 4 -> busy=0 immediately; after release, a write of 0x0042 to address 1 succeeds and reads back 0x0042.
